// File: rtl/note_acceptor_pkg.sv
// Shared definitions for the note acceptor and the vending machine that consumes its cash codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package note_acceptor_pkg;

  // Cash codes presented to the vending machine; 2'b11 is never driven.
  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] RS10 = 2'b01;
  localparam logic [1:0] RS20 = 2'b10;

  // Acceptor FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIGH  = 3'd1,
    ST_GAP   = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // Pulse counter of a train saturates here; anything above 2 is rejected anyway.
  localparam int         PCNT_W   = 3;
  localparam logic [2:0] PCNT_MAX = 3'd7;

  function automatic logic [PCNT_W-1:0] pcnt_inc(input logic [PCNT_W-1:0] c);
    return (c == PCNT_MAX) ? c : c + 3'd1;
  endfunction

endpackage

// File: rtl/note_acceptor_debounce.sv
// Synchronizes the raw validator line into clk and filters it into a clean level.
// Latency: a held raw edge reaches clean_o exactly SYNC_STAGES+DEBOUNCE_CYC cycles later.
// Backpressure: none; the clean level is continuously valid and never stalls.
module pulse_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  output logic clean_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign clean_o = clean_q;

  // Shift the asynchronous line through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pulse_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Count consecutive cycles the synchronized value disagrees with the clean level;
  // any agreeing cycle restarts the count, so short glitches never flip the level.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (synced != clean_q) begin
      if (cnt_q == DB_LAST) begin
        clean_d = synced;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce counter and clean level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

endmodule

// File: rtl/note_acceptor.sv
// Decodes validator pulse trains into a one-cycle cash code or reject strobe.
// Latency: result appears GAP_CYC cycles after the clean fall of the last pulse, for one cycle.
// Backpressure: none; cash/reject are single-cycle strobes with no handshake and are not held.
module note_acceptor
  import note_acceptor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 4,
  parameter int GAP_CYC       = 20,
  parameter int MAX_PULSE_CYC = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic       inhibit,
  output logic [1:0] cash,
  output logic       reject,
  output logic       busy,
  output logic       fault
);

  // One shared timer counts clean-high cycles in HIGH and clean-low cycles in GAP/FAULT.
  localparam int            TMAX     = (GAP_CYC > MAX_PULSE_CYC) ? GAP_CYC : MAX_PULSE_CYC;
  localparam int            TW       = $clog2(TMAX + 1);
  localparam logic [TW-1:0] GAP_LIM  = TW'(GAP_CYC);
  localparam logic [TW-1:0] HIGH_LIM = TW'(MAX_PULSE_CYC);

  state_e              state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                inh_q, inh_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [TW-1:0]       timer_inc;
  logic                clean;

  pulse_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .pulse_i(pulse_in),
    .clean_o(clean)
  );

  // Saturating increment keeps the timer from ever wrapping.
  assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);

  // Next-state logic. States are entered on the cycle after the clean level changes,
  // so the timer is preloaded with 1 to account for the cycle already elapsed.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    inh_d   = inh_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (clean) begin
          state_d = ST_HIGH;
          pcnt_d  = PCNT_W'(1);
          inh_d   = inhibit;
          timer_d = TW'(1);
        end
      end
      ST_HIGH: begin
        if (!clean) begin
          state_d = ST_GAP;
          timer_d = TW'(1);
        end else if (timer_inc >= HIGH_LIM) begin
          state_d = ST_FAULT;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_GAP: begin
        if (clean) begin
          state_d = ST_HIGH;
          pcnt_d  = pcnt_inc(pcnt_q);
          timer_d = TW'(1);
        end else if (timer_inc >= GAP_LIM) begin
          state_d = ST_EMIT;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_EMIT: begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
        inh_d   = 1'b0;
        timer_d = '0;
      end
      ST_FAULT: begin
        if (clean) begin
          timer_d = '0;
        end else if (timer_inc >= GAP_LIM) begin
          state_d = ST_IDLE;
          pcnt_d  = '0;
          inh_d   = 1'b0;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
        inh_d   = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  // FSM, pulse count, latched inhibit and timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      inh_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      inh_q   <= inh_d;
      timer_q <= timer_d;
    end
  end

  // Outputs decode from registered state only; cash and reject are mutually exclusive.
  always_comb begin
    cash   = NONE;
    reject = 1'b0;
    if (state_q == ST_EMIT) begin
      if (!inh_q && pcnt_q == PCNT_W'(1)) begin
        cash = RS10;
      end else if (!inh_q && pcnt_q == PCNT_W'(2)) begin
        cash = RS20;
      end else begin
        reject = 1'b1;
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_note_acceptor.sv
// Directed bench for note_acceptor with default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_note_acceptor;
  import note_acceptor_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse_in;
  logic       inhibit;
  logic [1:0] cash;
  logic       reject;
  logic       busy;
  logic       fault;

  int checks = 0;
  int errors = 0;

  note_acceptor dut (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .inhibit (inhibit),
    .cash    (cash),
    .reject  (reject),
    .busy    (busy),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  localparam int NMAX = 128;

  // Per-cycle stimulus: pulse_in, inhibit, rst.
  bit pw[$];
  bit iw[$];
  bit rw[$];

  // Per-cycle samples, taken at the falling edge before that cycle's drive.
  logic [1:0] cash_a [NMAX];
  logic       rej_a  [NMAX];
  logic       busy_a [NMAX];
  logic       fault_a[NMAX];
  int         nlen;

  task automatic clear_wave();
    pw.delete();
    iw.delete();
    rw.delete();
  endtask

  task automatic seg(input bit p, input bit i, input int n);
    for (int k = 0; k < n; k++) begin
      pw.push_back(p);
      iw.push_back(i);
      rw.push_back(1'b0);
    end
  endtask

  // Sample k reflects the DUT after the rising edge preceding drive k.
  task automatic play();
    nlen = (pw.size() > NMAX) ? NMAX : pw.size();
    for (int k = 0; k < nlen; k++) begin
      @(negedge clk);
      cash_a[k]  = cash;
      rej_a[k]   = reject;
      busy_a[k]  = busy;
      fault_a[k] = fault;
      pulse_in   = pw[k];
      inhibit    = iw[k];
      rst        = rw[k];
    end
  endtask

  function automatic int cnt_cash(input logic [1:0] v);
    int n = 0;
    for (int k = 0; k < nlen; k++) if (cash_a[k] === v) n++;
    return n;
  endfunction

  function automatic int first_cash(input logic [1:0] v);
    for (int k = 0; k < nlen; k++) if (cash_a[k] === v) return k;
    return -1;
  endfunction

  function automatic int cnt_rej();
    int n = 0;
    for (int k = 0; k < nlen; k++) if (rej_a[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_rej();
    for (int k = 0; k < nlen; k++) if (rej_a[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int first_busy();
    for (int k = 0; k < nlen; k++) if (busy_a[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int first_fault(input logic v, input int from);
    for (int k = from; k < nlen; k++) if (fault_a[k] === v) return k;
    return -1;
  endfunction

  function automatic int cnt_illegal();
    int n = 0;
    for (int k = 0; k < nlen; k++)
      if (cash_a[k] === 2'b11 || (cash_a[k] !== 2'b00 && rej_a[k] !== 1'b0)) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1; pulse_in = 1'b0; inhibit = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (cash !== NONE) begin errors++; $display("FAIL reset_cash got %b want 00", cash); end
    checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject got %b want 0", reject); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    clear_wave(); seg(1, 0, 10); seg(0, 0, 50); play();
    checks++; if (first_busy() !== 7) begin errors++; $display("FAIL single_busy_rise got %0d want 7", first_busy()); end
    checks++; if (cnt_cash(RS10) !== 1) begin errors++; $display("FAIL single_rs10_count got %0d want 1", cnt_cash(RS10)); end
    checks++; if (first_cash(RS10) !== 36) begin errors++; $display("FAIL single_rs10_time got %0d want 36", first_cash(RS10)); end
    checks++; if (cnt_rej() !== 0) begin errors++; $display("FAIL single_reject got %0d want 0", cnt_rej()); end
    checks++; if (busy_a[nlen-1] !== 1'b0) begin errors++; $display("FAIL single_idle_after got %b want 0", busy_a[nlen-1]); end
    checks++; if (cnt_illegal() !== 0) begin errors++; $display("FAIL single_exclusive got %0d want 0", cnt_illegal()); end
  endtask

  task automatic test_min_pulse();
    clear_wave(); seg(1, 0, 4); seg(0, 0, 40); play();
    checks++; if (first_cash(RS10) !== 30) begin errors++; $display("FAIL min_pulse_time got %0d want 30", first_cash(RS10)); end
    checks++; if (cnt_cash(RS10) !== 1) begin errors++; $display("FAIL min_pulse_count got %0d want 1", cnt_cash(RS10)); end
  endtask

  task automatic test_glitch();
    clear_wave();
    for (int g = 0; g < 3; g++) begin seg(1, 0, 2); seg(0, 0, 6); end
    for (int g = 0; g < 2; g++) begin seg(1, 0, 3); seg(0, 0, 6); end
    seg(0, 0, 10); play();
    checks++; if (first_busy() !== -1) begin errors++; $display("FAIL glitch_busy got %0d want -1", first_busy()); end
    checks++; if (cnt_cash(NONE) !== nlen) begin errors++; $display("FAIL glitch_cash got %0d want %0d", cnt_cash(NONE), nlen); end
    checks++; if (cnt_rej() !== 0) begin errors++; $display("FAIL glitch_reject got %0d want 0", cnt_rej()); end
  endtask

  task automatic test_two_pulses();
    int drops = 0;
    clear_wave(); seg(1, 0, 10); seg(0, 0, 10); seg(1, 0, 10); seg(0, 0, 50); play();
    for (int k = 7; k <= 56; k++) if (busy_a[k] !== 1'b1) drops++;
    checks++; if (cnt_cash(RS20) !== 1) begin errors++; $display("FAIL two_rs20_count got %0d want 1", cnt_cash(RS20)); end
    checks++; if (first_cash(RS20) !== 56) begin errors++; $display("FAIL two_rs20_time got %0d want 56", first_cash(RS20)); end
    checks++; if (cnt_cash(RS10) !== 0) begin errors++; $display("FAIL two_no_rs10 got %0d want 0", cnt_cash(RS10)); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL two_busy_hold got %0d want 0", drops); end
    checks++; if (cnt_rej() !== 0) begin errors++; $display("FAIL two_reject got %0d want 0", cnt_rej()); end
  endtask

  task automatic test_three_pulses();
    clear_wave();
    seg(1, 0, 10); seg(0, 0, 10); seg(1, 0, 10); seg(0, 0, 10); seg(1, 0, 10); seg(0, 0, 40); play();
    checks++; if (cnt_rej() !== 1) begin errors++; $display("FAIL three_reject_count got %0d want 1", cnt_rej()); end
    checks++; if (first_rej() !== 76) begin errors++; $display("FAIL three_reject_time got %0d want 76", first_rej()); end
    checks++; if (cnt_cash(NONE) !== nlen) begin errors++; $display("FAIL three_cash got %0d want %0d", cnt_cash(NONE), nlen); end
  endtask

  task automatic test_inhibit();
    clear_wave(); seg(1, 1, 10); seg(0, 1, 50); play();
    checks++; if (first_rej() !== 36) begin errors++; $display("FAIL inhibit_reject_time got %0d want 36", first_rej()); end
    checks++; if (cnt_cash(NONE) !== nlen) begin errors++; $display("FAIL inhibit_cash got %0d want %0d", cnt_cash(NONE), nlen); end
    // Inhibit rising after the train has started is ignored.
    clear_wave(); seg(1, 0, 8); seg(1, 1, 2); seg(0, 1, 50); play();
    checks++; if (first_cash(RS10) !== 36) begin errors++; $display("FAIL inhibit_late_set got %0d want 36", first_cash(RS10)); end
    checks++; if (cnt_rej() !== 0) begin errors++; $display("FAIL inhibit_late_set_rej got %0d want 0", cnt_rej()); end
    // Inhibit dropping after the train has started still rejects.
    clear_wave(); seg(1, 1, 8); seg(1, 0, 2); seg(0, 0, 50); play();
    checks++; if (first_rej() !== 36) begin errors++; $display("FAIL inhibit_late_clr got %0d want 36", first_rej()); end
    checks++; if (cnt_cash(NONE) !== nlen) begin errors++; $display("FAIL inhibit_late_clr_cash got %0d want %0d", cnt_cash(NONE), nlen); end
  endtask

  task automatic test_fault();
    clear_wave(); seg(1, 0, 60); seg(0, 0, 50); play();
    checks++; if (first_fault(1'b1, 0) !== 46) begin errors++; $display("FAIL fault_set got %0d want 46", first_fault(1'b1, 0)); end
    checks++; if (first_fault(1'b0, 46) !== 86) begin errors++; $display("FAIL fault_clear got %0d want 86", first_fault(1'b0, 46)); end
    checks++; if (cnt_cash(NONE) !== nlen || cnt_rej() !== 0) begin
      errors++; $display("FAIL fault_outputs got cash_none=%0d rej=%0d want %0d 0", cnt_cash(NONE), cnt_rej(), nlen);
    end
    checks++; if (busy_a[nlen-1] !== 1'b0) begin errors++; $display("FAIL fault_idle got %b want 0", busy_a[nlen-1]); end
  endtask

  task automatic test_reset_gap();
    clear_wave(); seg(1, 0, 10); seg(0, 0, 16); play();
    checks++; if (busy_a[25] !== 1'b1) begin errors++; $display("FAIL rstgap_busy_before got %b want 1", busy_a[25]); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rstgap_async got busy=%b fault=%b want 0 0", busy, fault); end
    checks++; if (cash !== NONE || reject !== 1'b0) begin errors++; $display("FAIL rstgap_async_out got cash=%b rej=%b want 00 0", cash, reject); end
    clear_wave(); seg(0, 0, 40); rw[0] = 1'b1; rw[1] = 1'b1; play();
    checks++; if (cnt_cash(NONE) !== nlen || cnt_rej() !== 0) begin
      errors++; $display("FAIL rstgap_no_strobe got cash_none=%0d rej=%0d want %0d 0", cnt_cash(NONE), cnt_rej(), nlen);
    end
    checks++; if (first_busy() !== -1) begin errors++; $display("FAIL rstgap_busy_after got %0d want -1", first_busy()); end
  endtask

  task automatic test_reset_high();
    clear_wave(); seg(1, 0, 60); seg(0, 0, 40); rw[20] = 1'b1; rw[21] = 1'b1; play();
    checks++; if (busy_a[20] !== 1'b1 || busy_a[21] !== 1'b0) begin
      errors++; $display("FAIL rsthigh_drop got %b%b want 10", busy_a[20], busy_a[21]);
    end
    checks++; if (busy_a[28] !== 1'b0 || busy_a[29] !== 1'b1) begin
      errors++; $display("FAIL rsthigh_rerise got %b%b want 01", busy_a[28], busy_a[29]);
    end
    checks++; if (first_cash(RS10) !== 86) begin errors++; $display("FAIL rsthigh_cash got %0d want 86", first_cash(RS10)); end
    checks++; if (first_fault(1'b1, 0) !== -1) begin errors++; $display("FAIL rsthigh_fault got %0d want -1", first_fault(1'b1, 0)); end
  endtask

  task automatic test_back_to_back();
    clear_wave(); seg(1, 0, 10); seg(0, 0, 30); seg(1, 0, 10); seg(0, 0, 50); play();
    checks++; if (cnt_cash(RS10) !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", cnt_cash(RS10)); end
    checks++; if (cash_a[36] !== RS10 || cash_a[76] !== RS10) begin
      errors++; $display("FAIL b2b_times got %b %b want 01 01", cash_a[36], cash_a[76]);
    end
    checks++; if (busy_a[40] !== 1'b0) begin errors++; $display("FAIL b2b_idle_between got %b want 0", busy_a[40]); end
    checks++; if (cnt_illegal() !== 0) begin errors++; $display("FAIL b2b_exclusive got %0d want 0", cnt_illegal()); end
  endtask

  initial begin
    rst = 1'b1;
    pulse_in = 1'b0;
    inhibit = 1'b0;
    test_reset();
    test_single();
    test_min_pulse();
    test_glitch();
    test_two_pulses();
    test_three_pulses();
    test_inhibit();
    test_fault();
    test_reset_gap();
    test_reset_high();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_acceptor.md
NOTE_ACCEPTOR -- requirements
Module: note_acceptor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops on pulse_in.
REQ-002 Parameter DEBOUNCE_CYC, default 4: cycles a level must be stable before it is accepted.
REQ-003 Parameter GAP_CYC, default 20: clean-low cycles that end a pulse train.
REQ-004 Parameter MAX_PULSE_CYC, default 40: clean-high cycles that declare the line stuck.
REQ-005 clk  input  1  system clock; all state on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 pulse_in  input  1  raw validator pulse line, asynchronous to clk; one pulse means Rs 10, two pulses mean Rs 20.
REQ-008 inhibit  input  1  from the vending machine; 1 means no note may be credited.
REQ-009 cash  output  2  note code to the vending machine: 00 none, 01 Rs 10, 10 Rs 20, 11 never driven.
REQ-010 reject  output  1  one-cycle strobe: a train ended with no credit.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 fault  output  1  high while in FAULT.

Function
REQ-013 pulse_in SHALL pass through SYNC_STAGES flops, then a debouncer; the clean level SHALL change only after the synchronized value differs from it for DEBOUNCE_CYC consecutive cycles.
REQ-014 A raw edge held stable SHALL reach the clean level exactly SYNC_STAGES+DEBOUNCE_CYC cycles later; glitches shorter than DEBOUNCE_CYC cycles SHALL be ignored.
REQ-015 FSM states: IDLE, HIGH, GAP, EMIT, FAULT.
REQ-016 IDLE -> HIGH on a clean rising edge; pulse count := 1; inhibit is sampled into a latched flag at this edge.
REQ-017 HIGH -> GAP on a clean falling edge; HIGH -> FAULT if clean high for MAX_PULSE_CYC cycles.
REQ-018 GAP -> HIGH on a clean rising edge; pulse count increments, saturating at 7.
REQ-019 GAP -> EMIT when the clean level has been low for GAP_CYC cycles (counter cleared at every clean edge).
REQ-020 EMIT lasts exactly one cycle, then -> IDLE.
REQ-021 In EMIT: count 1 and flag clear -> cash=01; count 2 and flag clear -> cash=10; any other count, or flag set -> reject=1, cash=00.
REQ-022 cash SHALL be 00 and reject 0 in every cycle outside EMIT; cash and reject SHALL never both be nonzero.
REQ-023 inhibit changes after the first rising edge of a train SHALL NOT affect that train.
REQ-024 FAULT -> IDLE after the clean level has been low for GAP_CYC consecutive cycles; no cash or reject on exit.
REQ-025 Timers SHALL be sized by $clog2 of their parameter and SHALL not wrap.

Reset
REQ-026 On rst: FSM=IDLE, counters, inhibit flag, synchronizer and clean level = 0; cash=00, reject=0, busy=0, fault=0.
REQ-027 Reset asserted mid-train or in EMIT SHALL discard the train with no cash or reject; after release a line still high SHALL be seen as a new rising edge only after SYNC_STAGES+DEBOUNCE_CYC cycles.

Structure
REQ-028 A shared package SHALL hold the cash code constants (NONE, RS10, RS20) and the FSM state enum, for use by the vending machine and this block.
REQ-029 The synchronizer plus debouncer SHALL be one sub-module, pulse_debounce, parameterized by SYNC_STAGES and DEBOUNCE_CYC.

Verification (defaults)
REQ-030 One raw pulse 10 cycles high, inhibit=0 -> busy rises; exactly one cycle with cash=01 occurring GAP_CYC cycles after the clean fall; reject never asserted.
REQ-031 Two pulses 10 high / 10 low -> exactly one cash=10 strobe; no 01 strobe between the pulses.
REQ-032 Three pulses -> one reject strobe, cash stays 00; inhibit=1 at the first edge with a single pulse -> one reject strobe, cash 00.
REQ-033 2-cycle glitches on pulse_in -> busy stays 0, no outputs.
REQ-034 pulse_in held high 60 cycles -> fault=1 after MAX_PULSE_CYC clean-high cycles; released -> fault=0 GAP_CYC cycles after the clean fall, no cash.
REQ-035 rst pulsed during GAP of a one-pulse train -> all outputs 0 immediately, no cash strobe afterwards.
